inst_cache: RTL

//  Read-only, direct-mapped instruction cache. It responds to the IF stage's instruction-fetch port (inst_read/inst_addr).
//  It sits between the IF stage and the physical-memory arbiter/port and serves 32-bit instruction words.

---
 rtl/inst_cache.sv | 94 +++++++++
 1 files changed

// File: rtl/inst_cache.sv
// Read-only direct-mapped instruction cache: hits answer combinationally in IDLE,
// misses fetch one full line from physical memory in FETCH and retry as a hit.
module inst_cache #(
  parameter int unsigned S_INDEX  = 3,
  parameter int unsigned S_OFFSET = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inst_read,
  input  logic [31:0]  inst_addr,
  output logic [31:0]  inst_rdata,
  output logic         inst_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned SETS   = 1 << S_INDEX;
  localparam int unsigned WORDS  = (1 << S_OFFSET) / 4;
  localparam int unsigned TAG_W  = 32 - S_OFFSET - S_INDEX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                   state;
  logic [SETS-1:0]          valid;
  logic [TAG_W-1:0]         tag_arr  [SETS];
  logic [WORDS-1:0][31:0]   data_arr [SETS];

  logic [S_INDEX-1:0]       index;
  logic [TAG_W-1:0]         tag;
  logic [S_OFFSET-3:0]      word;
  logic                     hit;
  logic                     fill;
  logic                     unused_addr_bits;

  assign index            = inst_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign tag              = inst_addr[31:S_OFFSET+S_INDEX];
  assign word             = inst_addr[S_OFFSET-1:2];
  assign unused_addr_bits = ^inst_addr[1:0];

  assign hit  = inst_read && valid[index] && (tag_arr[index] == tag);
  assign fill = (state == FETCH) && pmem_resp && !reset;

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_arr[index] <= pmem_rdata;
      tag_arr[index]  <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_read && !hit) state <= FETCH;
        end
        FETCH: begin
          if (pmem_resp) begin
            valid[index] <= 1'b1;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

  // Outputs are forced low while reset is held so a fetch in flight is dropped at once.
  always_comb begin
    inst_resp    = 1'b0;
    inst_rdata   = '0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (hit) begin
            inst_resp  = 1'b1;
            inst_rdata = data_arr[index][word];
          end
        end
        FETCH: begin
          pmem_read    = 1'b1;
          pmem_address = {inst_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
        end
      endcase
    end
  end

endmodule
